// File: rtl/note_pkg.sv
// Shared types and helpers for the ADSR voice.
package note_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } env_state_e;

    // Full-scale envelope value for a given envelope width.
    function automatic logic [31:0] env_full(input int unsigned width);
        return 32'((64'd1 << width) - 64'd1);
    endfunction

endpackage

// File: rtl/sin_lut.sv
// Quarter-wave mirrored sine table: theta in, signed sample out (combinational).
// The stored quarter has 65 points (0..pi/2 inclusive) so the peak lands exactly on
// theta = 2^(THETA_WIDTH-2). THETA_WIDTH must be at least 8.
module sin_lut #(
    parameter int unsigned THETA_WIDTH = 8,
    parameter int unsigned AM_WIDTH    = 8
) (
    input  logic        [THETA_WIDTH-1:0] theta_i,
    output logic signed [AM_WIDTH-1:0]    sine_c_o
);

    localparam int unsigned QW   = THETA_WIDTH - 2;
    localparam int unsigned PEAK = (2 ** (AM_WIDTH - 1)) - 1;
    localparam int unsigned SW   = AM_WIDTH + 7;

    // round(127 * sin(i * pi / 128)), i = 0..64
    localparam logic [6:0] QTAB [0:64] = '{
        7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,  7'd25,  7'd28,
        7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,  7'd49,  7'd51,  7'd54,  7'd57,
        7'd60,  7'd63,  7'd65,  7'd68,  7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,
        7'd85,  7'd88,  7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
        7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116, 7'd117, 7'd118,
        7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124, 7'd125, 7'd125, 7'd126, 7'd126,
        7'd126, 7'd127, 7'd127, 7'd127, 7'd127
    };

    logic [1:0]          quad_w;
    logic [QW:0]         mir_w;
    logic [6:0]          tix_w;
    logic [6:0]          mag_w;
    logic [SW-1:0]       scaled_w;
    logic [AM_WIDTH-1:0] pos_w;

    // Fold theta into the first quadrant, look up, rescale, then restore the sign.
    assign quad_w   = theta_i[THETA_WIDTH-1 -: 2];
    assign mir_w    = quad_w[0] ? ((QW+1)'(2 ** QW) - {1'b0, theta_i[QW-1:0]})
                                : {1'b0, theta_i[QW-1:0]};
    assign tix_w    = 7'(mir_w >> (QW - 6));
    assign mag_w    = QTAB[tix_w];
    assign scaled_w = (SW'(mag_w) * SW'(PEAK)) / SW'(127);
    assign pos_w    = AM_WIDTH'(scaled_w);
    assign sine_c_o = quad_w[1] ? $signed(-pos_w) : $signed(pos_w);

endmodule

// File: rtl/note_adsr_voice.sv
// Single-voice tone generator: phase accumulator, sine table and ADSR envelope.
module note_adsr_voice
    import note_pkg::*;
#(
    parameter int unsigned THETA_WIDTH = 8,
    parameter int unsigned AM_WIDTH    = 8,
    parameter int unsigned ACC_WIDTH   = 24,
    parameter int unsigned ENV_WIDTH   = 16
) (
    input  logic                        clk_theta,
    input  logic                        rst,
    input  logic        [7:0]           noteid,
    input  logic        [ACC_WIDTH-1:0] phase_inc,
    input  logic        [ENV_WIDTH-1:0] attack_step,
    input  logic        [3:0]           decay_shift,
    input  logic        [ENV_WIDTH-1:0] sustain_lvl,
    input  logic        [3:0]           release_shift,
    output logic signed [AM_WIDTH-1:0]  am,
    output logic        [ENV_WIDTH-1:0] env,
    output logic                        active
);

    localparam logic [ENV_WIDTH-1:0] ENV_FULL   = ENV_WIDTH'(env_full(ENV_WIDTH));
    localparam int unsigned          PROD_WIDTH = AM_WIDTH + ENV_WIDTH + 1;

    env_state_e                 state_q, state_d;
    logic        [ACC_WIDTH-1:0] acc_q, acc_d;
    logic        [ENV_WIDTH-1:0] env_q, env_d;
    logic signed [AM_WIDTH-1:0]  am_q, am_d;
    logic        [7:0]           note_q, note_d;
    logic                        active_q, active_d;

    logic        [THETA_WIDTH-1:0] theta_w;
    logic signed [AM_WIDTH-1:0]    sine_w;
    logic signed [PROD_WIDTH-1:0]  prod_w;
    logic signed [PROD_WIDTH-1:0]  prod_shr_w;
    logic                          trigger_w;
    logic                          release_w;
    logic        [ENV_WIDTH:0]     att_sum_w;
    logic        [ENV_WIDTH:0]     sus_thr_w;
    logic        [ENV_WIDTH-1:0]   dec_w;
    logic        [ENV_WIDTH-1:0]   rel_w;

    // Envelope step of max(v >> sh, 1) so decay and release always make progress.
    function automatic logic [ENV_WIDTH-1:0] min_one_shr(input logic [ENV_WIDTH-1:0] v,
                                                         input logic [3:0] sh);
        logic [ENV_WIDTH-1:0] s;
        s = v >> sh;
        return (s == '0) ? ENV_WIDTH'(1) : s;
    endfunction

    sin_lut #(
        .THETA_WIDTH (THETA_WIDTH),
        .AM_WIDTH    (AM_WIDTH)
    ) u_sin_lut (
        .theta_i  (theta_w),
        .sine_c_o (sine_w)
    );

    assign theta_w    = acc_q[ACC_WIDTH-1 -: THETA_WIDTH];
    assign prod_w     = PROD_WIDTH'(sine_w) * PROD_WIDTH'($signed({1'b0, env_q}));
    assign prod_shr_w = prod_w >>> ENV_WIDTH;
    assign trigger_w  = (noteid != 8'd0) && (noteid != note_q);
    assign release_w  = (noteid == 8'd0) && (note_q != 8'd0);
    assign att_sum_w  = {1'b0, env_q} + {1'b0, attack_step};
    assign dec_w      = min_one_shr(env_q, decay_shift);
    assign rel_w      = min_one_shr(env_q, release_shift);
    assign sus_thr_w  = {1'b0, sustain_lvl} + {1'b0, dec_w};

    // Next-state: envelope FSM, phase step, note tracking; trigger overrides everything.
    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        acc_d   = acc_q + phase_inc;
        note_d  = note_q;
        am_d    = AM_WIDTH'(prod_shr_w);

        case (state_q)
            IDLE: env_d = '0;
            ATTACK: begin
                if (att_sum_w >= {1'b0, ENV_FULL}) begin
                    env_d   = ENV_FULL;
                    state_d = DECAY;
                end else begin
                    env_d = att_sum_w[ENV_WIDTH-1:0];
                end
            end
            DECAY: begin
                if ({1'b0, env_q} <= sus_thr_w) begin
                    env_d   = sustain_lvl;
                    state_d = SUSTAIN;
                end else begin
                    env_d = env_q - dec_w;
                end
            end
            SUSTAIN: env_d = sustain_lvl;
            RELEASE: begin
                if (env_q <= rel_w) begin
                    env_d   = '0;
                    state_d = IDLE;
                end else begin
                    env_d = env_q - rel_w;
                end
            end
            default: begin
                env_d   = '0;
                state_d = IDLE;
            end
        endcase

        if (release_w) begin
            if (state_q != IDLE) state_d = RELEASE;
            note_d = '0;
        end

        // Retrigger keeps the current envelope level to avoid a click.
        if (trigger_w) begin
            acc_d   = '0;
            state_d = ATTACK;
            env_d   = env_q;
            note_d  = noteid;
        end

        active_d = (state_d != IDLE);
    end

    // State register with asynchronous reset.
    always_ff @(posedge clk_theta or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            env_q    <= '0;
            am_q     <= '0;
            note_q   <= '0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            env_q    <= env_d;
            am_q     <= am_d;
            note_q   <= note_d;
            active_q <= active_d;
        end
    end

    assign am     = am_q;
    assign env    = env_q;
    assign active = active_q;

endmodule

// File: tb/tb_note_adsr_voice.sv
// Directed bench for note_adsr_voice: reset, full ADSR, sine phase, retrigger, boundaries.
module tb_note_adsr_voice;

    logic               clk_theta = 1'b0;
    logic               rst;
    logic        [7:0]  noteid;
    logic        [23:0] phase_inc;
    logic        [15:0] attack_step;
    logic        [3:0]  decay_shift;
    logic        [15:0] sustain_lvl;
    logic        [3:0]  release_shift;
    logic signed [7:0]  am;
    logic        [15:0] env;
    logic               active;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] prev_env, r_step, exp_env;

    note_adsr_voice dut (
        .clk_theta     (clk_theta),
        .rst           (rst),
        .noteid        (noteid),
        .phase_inc     (phase_inc),
        .attack_step   (attack_step),
        .decay_shift   (decay_shift),
        .sustain_lvl   (sustain_lvl),
        .release_shift (release_shift),
        .am            (am),
        .env           (env),
        .active        (active)
    );

    always #5 clk_theta = ~clk_theta;

    task automatic step();
        @(posedge clk_theta);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b0;
        noteid        = 8'd0;
        phase_inc     = 24'h010000;
        attack_step   = 16'h1000;
        decay_shift   = 4'd4;
        sustain_lvl   = 16'h8000;
        release_shift = 4'd3;
        #1 rst = 1'b1;
        #20;
        check("reset_env", 32'(env), 32'h0);
        check("reset_am", 32'(am), 32'h0);
        check("reset_active", 32'(active), 32'h0);

        // Full ADSR with default settings
        rst    = 1'b0;
        noteid = 8'd60;
        step();
        check("trig_env", 32'(env), 32'h0);
        check("trig_active", 32'(active), 32'h1);
        for (int i = 1; i <= 15; i++) begin
            step();
            check("attack_ramp", 32'(env), 32'(i * 32'h1000));
        end
        step();
        check("attack_peak", 32'(env), 32'hFFFF);
        step();
        check("decay_first", 32'(env), 32'hF000);
        for (int i = 0; i < 64 && env != 16'h8000; i++) step();
        check("sustain_reached", 32'(env), 32'h8000);
        step();
        check("sustain_hold", 32'(env), 32'h8000);
        check("sustain_active", 32'(active), 32'h1);

        noteid = 8'd0;
        step();
        check("rel_req_env", 32'(env), 32'h8000);
        step();
        check("rel_first", 32'(env), 32'h7000);
        prev_env = env;
        for (int i = 0; i < 400 && active; i++) begin
            step();
            r_step = prev_env >> 3;
            if (r_step == 16'd0) r_step = 16'd1;
            exp_env = (prev_env <= r_step) ? 16'd0 : prev_env - r_step;
            check("rel_step", 32'(env), 32'(exp_env));
            prev_env = env;
        end
        check("rel_end_env", 32'(env), 32'h0);
        check("rel_end_active", 32'(active), 32'h0);

        // Phase and table with envelope pinned at full scale
        rst = 1'b1;
        #2;
        rst           = 1'b0;
        attack_step   = 16'hFFFF;
        decay_shift   = 4'd0;
        sustain_lvl   = 16'hFFFF;
        phase_inc     = 24'h010000;
        noteid        = 8'd60;
        step();
        check("ph_trig_env", 32'(env), 32'h0);
        step();
        check("ph_full_env", 32'(env), 32'hFFFF);
        check("ph_am_env0", 32'(am), 32'h0);
        for (int k = 2; k <= 258; k++) begin
            step();
            if (k == 2)        check("ph_theta1", 32'(am), 32'(2));
            else if (k == 33)  check("ph_theta32", 32'(am), 32'(89));
            else if (k == 65)  check("ph_peak", 32'(am), 32'(126));
            else if (k == 129) check("ph_zero", 32'(am), 32'(0));
            else if (k == 161) check("ph_theta160", 32'(am), -32'sd90);
            else if (k == 193) check("ph_trough", 32'(am), -32'sd127);
            else if (k == 257) check("ph_wrap0", 32'(am), 32'(0));
            else if (k == 258) check("ph_wrap1", 32'(am), 32'(2));
        end

        // phase_inc = 0 holds theta at 2
        phase_inc = 24'h0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("ph_hold", 32'(am), 32'(5));
        end

        // Retrigger straight from SUSTAIN clears the phase
        phase_inc = 24'h010000;
        noteid    = 8'd62;
        step();
        check("rt_sus_am", 32'(am), 32'(5));
        check("rt_sus_env", 32'(env), 32'hFFFF);
        step();
        check("rt_sus_acc0", 32'(am), 32'(0));
        step();
        check("rt_sus_acc1", 32'(am), 32'(2));

        // Retrigger during RELEASE starts ATTACK from the current level
        sustain_lvl = 16'h4000;
        step();
        check("rt_rel_sus", 32'(env), 32'h4000);
        noteid = 8'd0;
        step();
        check("rt_rel_req", 32'(env), 32'h4000);
        check("rt_rel_active", 32'(active), 32'h1);
        attack_step = 16'h1000;
        noteid      = 8'd62;
        step();
        check("rt_rel_trig", 32'(env), 32'h4000);
        step();
        check("rt_rel_attack", 32'(env), 32'h5000);
        check("rt_rel_acc0", 32'(am), 32'(0));

        // sustain_lvl = 0: decay lands at zero but the voice stays active
        attack_step = 16'hFFFF;
        sustain_lvl = 16'h0;
        decay_shift = 4'd4;
        step();
        check("sus0_peak", 32'(env), 32'hFFFF);
        for (int i = 0; i < 400 && env != 16'h0; i++) step();
        check("sus0_env", 32'(env), 32'h0);
        step();
        check("sus0_env_hold", 32'(env), 32'h0);
        check("sus0_active", 32'(active), 32'h1);
        check("sus0_am", 32'(am), 32'h0);

        // Attack saturation from env = 2
        sustain_lvl = 16'h0002;
        step();
        check("sat_env2", 32'(env), 32'h2);
        noteid = 8'd64;
        step();
        check("sat_trig", 32'(env), 32'h2);
        step();
        check("sat_full", 32'(env), 32'hFFFF);

        // release_shift = 15 from env = 3
        decay_shift = 4'd0;
        sustain_lvl = 16'h0003;
        step();
        check("rs15_sus", 32'(env), 32'h3);
        release_shift = 4'd15;
        noteid        = 8'd0;
        step();
        check("rs15_req", 32'(env), 32'h3);
        step();
        check("rs15_2", 32'(env), 32'h2);
        step();
        check("rs15_1", 32'(env), 32'h1);
        check("rs15_active1", 32'(active), 32'h1);
        step();
        check("rs15_0", 32'(env), 32'h0);
        check("rs15_idle", 32'(active), 32'h0);

        // Reset in SUSTAIN, then restart with the key still held
        sustain_lvl = 16'h8000;
        noteid      = 8'd60;
        step();
        step();
        step();
        step();
        check("rst_pre_env", 32'(env), 32'h8000);
        check("rst_pre_am", 32'(am), 32'(3));
        #2 rst = 1'b1;
        #1;
        check("rst_mid_env", 32'(env), 32'h0);
        check("rst_mid_am", 32'(am), 32'h0);
        check("rst_mid_active", 32'(active), 32'h0);
        #2 rst = 1'b0;
        step();
        check("rst_restart_env", 32'(env), 32'h0);
        check("rst_restart_active", 32'(active), 32'h1);
        step();
        check("rst_restart_attack", 32'(env), 32'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
